// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Used by bin_to_bcd_seq and bcd_add3.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DIGIT_W     = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;
    localparam logic [3:0]  ADD3_VAL    = 4'd3;

    // Elaboration-time helper for the digit-capacity check.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble correction cell: a digit of 5 or more gets +3
// (4-bit result, carry discarded) before the next left shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADD3_THRESH) begin
            o_digit = i_digit + ADD3_VAL;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter with a valid/ready request
// handshake. Optional leading-zero mask output under `BCD_LZ_MASK_EN.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DIGITS = 3
) (
    input  logic                      CLOCK_50,
    input  logic                      RST_N,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [WIDTH-1:0]          BIN,
    output logic                      OUT_VALID,
    output logic [DIGIT_W*DIGITS-1:0] BCD,
`ifdef BCD_LZ_MASK_EN
    output logic [DIGITS-1:0]         LZ_MASK,
`endif
    output logic                      BUSY
);

    localparam int unsigned ACC_W = DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digit_check
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_shift;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_corr;
    logic [ACC_W-1:0]    w_acc_next;
    logic [ACC_W-1:0]    r_bcd;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_last;

    assign w_accept   = (r_state == IDLE) && IN_VALID;
    assign w_last     = (r_state == SHIFT) && (r_cnt == CNT_W'(1));
    // Correct every digit first, then shift the MSB of the binary operand in.
    assign w_acc_next = {w_corr[ACC_W-2:0], r_shift[WIDTH-1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_acc[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_corr[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (IN_VALID) w_next = SHIFT;
            SHIFT:   if (w_last)   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
        end else if (w_accept) begin
            r_shift <= BIN;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(WIDTH);
        end else if (r_state == SHIFT) begin
            r_shift <= r_shift << 1;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_bcd <= w_acc_next;
            end
        end
    end

`ifdef BCD_LZ_MASK_EN
    logic [DIGITS-1:0] w_lz;
    logic [DIGITS-1:0] r_lz;
    logic              w_zero_run;

    // Walk from the most-significant digit down; the units bit stays 0.
    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (w_acc_next[i*DIGIT_W +: DIGIT_W] != '0) begin
                w_zero_run = 1'b0;
            end
            w_lz[i] = w_zero_run;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_lz <= '0;
        end else if (w_last) begin
            r_lz <= w_lz;
        end
    end

    assign LZ_MASK = r_lz;
`endif

    assign IN_READY  = (r_state == IDLE);
    assign BUSY      = (r_state == SHIFT);
    assign OUT_VALID = (r_state == DONE);
    assign BCD       = r_bcd;

endmodule
